// File: rtl/spi_periferico_esclavo.sv
// spi_periferico_esclavo: SPI mode-0 peripheral responder with SPI pins oversampled on clk_i.
// Define SPI_ESCLAVO_ECO_EN to echo the last received word when no response word is held.
module spi_periferico_esclavo #(
  parameter int unsigned       DATA_W       = 8,
  parameter int unsigned       SYNC_STAGES  = 2,
  parameter logic [DATA_W-1:0] IDLE_PATTERN = '1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sclk_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_dato_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_dato_o,
  output logic              rx_valid_o,
  input  logic              rx_leer_i,
  output logic              overrun_o,
  output logic              busy_o
);

  localparam int unsigned       CW       = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0]     CNT_FULL = CW'(DATA_W);

  typedef enum logic [1:0] {IDLE, CARGA, TRANSFER} estado_t;

  estado_t                r_estado;
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sclk_d, r_cs_d;
  logic [DATA_W-1:0]      r_tx_sh, r_rx_sh, r_hold, r_rx_dato;
  logic                   r_hold_full, r_oe, r_busy, r_fin, r_rx_valid, r_ovr;
  logic [CW-1:0]          r_cnt;
`ifdef SPI_ESCLAVO_ECO_EN
  logic                   r_have_rx;
`endif

  logic w_sclk, w_cs, w_mosi;
  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
  logic w_reload, w_take, w_tx_acc;
  logic [DATA_W-1:0] w_carga_word;

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_cs_fall   = ~w_cs & r_cs_d;
  assign w_cs_rise   = w_cs & ~r_cs_d;

  assign w_reload = (r_estado == TRANSFER) && !w_cs_rise && w_sclk_fall && (r_cnt == CNT_FULL);
  assign w_take   = (r_estado == CARGA) || w_reload;
  assign w_tx_acc = tx_valid_i && !r_hold_full;

  always_comb begin
    w_carga_word = IDLE_PATTERN;
    if (r_hold_full) w_carga_word = r_hold;
`ifdef SPI_ESCLAVO_ECO_EN
    else if (r_have_rx) w_carga_word = r_rx_dato;
`endif
  end

  // Synchronisers reset to the idle bus state so release never fakes a cs_n edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n_i};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs;
    end
  end

  // A new offer wins over a consume in the same cycle; the shift register saw the old content.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_tx_acc) begin
      r_hold      <= tx_dato_i;
      r_hold_full <= 1'b1;
    end else if (w_take) begin
      r_hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_estado <= IDLE;
      r_tx_sh  <= '1;
      r_rx_sh  <= '0;
      r_cnt    <= '0;
      r_oe     <= 1'b0;
      r_busy   <= 1'b0;
      r_fin    <= 1'b0;
    end else begin
      r_fin <= 1'b0;
      case (r_estado)
        IDLE: begin
          r_tx_sh <= '1;
          r_oe    <= 1'b0;
          r_busy  <= 1'b0;
          if (w_cs_fall) r_estado <= CARGA;
        end
        CARGA: begin
          r_tx_sh  <= w_carga_word;
          r_cnt    <= '0;
          r_oe     <= 1'b1;
          r_busy   <= 1'b1;
          r_estado <= TRANSFER;
          if (w_cs_rise) begin
            r_estado <= IDLE;
            r_oe     <= 1'b0;
            r_busy   <= 1'b0;
          end
        end
        TRANSFER: begin
          if (w_cs_rise) begin
            r_estado <= IDLE;
            r_tx_sh  <= '1;
            r_cnt    <= '0;
            r_oe     <= 1'b0;
            r_busy   <= 1'b0;
          end else if (w_sclk_rise) begin
            r_rx_sh <= {r_rx_sh[DATA_W-2:0], w_mosi};
            r_cnt   <= r_cnt + CW'(1);
            if (r_cnt == CNT_LAST) r_fin <= 1'b1;
          end else if (w_sclk_fall) begin
            if (r_cnt == CNT_FULL) begin
              r_tx_sh <= w_carga_word;
              r_cnt   <= '0;
            end else begin
              r_tx_sh <= {r_tx_sh[DATA_W-2:0], 1'b1};
            end
          end
        end
        default: r_estado <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rx_dato  <= '0;
      r_rx_valid <= 1'b0;
      r_ovr      <= 1'b0;
    end else if (r_fin) begin
      r_rx_dato  <= r_rx_sh;
      r_rx_valid <= 1'b1;
      if (r_rx_valid && !rx_leer_i) r_ovr <= 1'b1;
    end else if (rx_leer_i) begin
      r_rx_valid <= 1'b0;
    end
  end

`ifdef SPI_ESCLAVO_ECO_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)     r_have_rx <= 1'b0;
    else if (r_fin) r_have_rx <= 1'b1;
  end
`endif

  assign miso_o     = r_tx_sh[DATA_W-1];
  assign miso_oe_o  = r_oe;
  assign busy_o     = r_busy;
  assign tx_ready_o = ~r_hold_full;
  assign rx_dato_o  = r_rx_dato;
  assign rx_valid_o = r_rx_valid;
  assign overrun_o  = r_ovr;

endmodule
